master_config_rx: RTL and testbench

Master-side receiver for the serial configuration stream that the top-level controller drives during the `config_masters` main state. It deserialises one MSB-first configuration frame (slave id, read/write, external-write, start address, end address), framed by the `config_sub_state_t` codes. It validates the frame's length and address ordering, then presents the decoded fields, with a one-cycle valid pulse, to the master's transaction logic. There is one instance per master, between the top controller and each master core.

---
 rtl/top_details_pkg.sv | 23 ++
 rtl/master_config_rx.sv | 196 +++++++++++++++++++
 tb/tb_master_config_rx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/top_details_pkg.sv
// Shared top-level controller definitions: configuration sub-state codes
// driven on the serial config bus, and the master-side receiver states.
package top_details;

  // Sub-state code that accompanies each configuration bit.
  typedef enum logic [2:0] {
    config_start  = 3'd1,
    config_middle = 3'd2,
    config_last   = 3'd3,
    config_done   = 3'd4
  } config_sub_state_t;

  // No bit is presented on the bus this cycle.
  localparam logic [2:0] CONFIG_IDLE = 3'd0;

  // Receiver progress through one configuration frame.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_DONE = 2'd2
  } config_rx_state_t;

endpackage

// File: rtl/master_config_rx.sv
// Master-side configuration receiver. Deserialises one MSB-first frame
// {slave_id, read_write, ext_write, start_addr, end_addr}, checks its length
// and address ordering, then publishes the fields with a one-cycle valid
// pulse. Malformed frames produce a one-cycle error pulse instead.
module master_config_rx
  import top_details::*;
#(
  parameter int SLAVE_ID_W = 2,
  parameter int ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            config_state,
  input  logic                  config_bit,
  output logic [SLAVE_ID_W-1:0] slave_id,
  output logic                  read_write,
  output logic                  ext_write,
  output logic [ADDR_W-1:0]     start_addr,
  output logic [ADDR_W-1:0]     end_addr,
  output logic                  cfg_valid,
  output logic                  cfg_error,
  output logic                  rx_busy
);

  localparam int FRAME_LEN = SLAVE_ID_W + 2 + 2 * ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  // Bit positions of each field inside the fully shifted frame.
  localparam int END_LSB   = 0;
  localparam int START_LSB = ADDR_W;
  localparam int EXT_POS   = 2 * ADDR_W;
  localparam int RW_POS    = 2 * ADDR_W + 1;
  localparam int SID_LSB   = 2 * ADDR_W + 2;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST_MID = CNT_W'(FRAME_LEN - 1);

  config_rx_state_t        state_r, next_state_s;
  logic [FRAME_LEN-1:0]    shift_r, shift_nxt_s, shifted_s;
  logic [CNT_W-1:0]        bit_cnt_r, cnt_nxt_s, cnt_inc_s;
  logic                    valid_nxt_s, error_nxt_s, load_s;

  logic [SLAVE_ID_W-1:0]   slave_id_r;
  logic                    read_write_r, ext_write_r;
  logic [ADDR_W-1:0]       start_addr_r, end_addr_r;
  logic                    cfg_valid_r, cfg_error_r, rx_busy_r;

  logic [SLAVE_ID_W-1:0]   sid_fld_s;
  logic                    rw_fld_s, ext_fld_s;
  logic [ADDR_W-1:0]       start_fld_s, end_fld_s;

  assign shifted_s = {shift_r[FRAME_LEN-2:0], config_bit};
  assign cnt_inc_s = bit_cnt_r + CNT_ONE;

  assign sid_fld_s   = shift_r[SID_LSB +: SLAVE_ID_W];
  assign rw_fld_s    = shift_r[RW_POS];
  assign ext_fld_s   = shift_r[EXT_POS];
  assign start_fld_s = shift_r[START_LSB +: ADDR_W];
  assign end_fld_s   = shift_r[END_LSB +: ADDR_W];

  // Next-state, shift/count update and pulse decisions for each bus code.
  always_comb begin
    next_state_s = state_r;
    shift_nxt_s  = shift_r;
    cnt_nxt_s    = bit_cnt_r;
    valid_nxt_s  = 1'b0;
    error_nxt_s  = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        case (config_state)
          config_start: begin
            shift_nxt_s  = shifted_s;
            cnt_nxt_s    = CNT_ONE;
            next_state_s = SHIFT;
          end
          config_middle, config_last: begin
            error_nxt_s = 1'b1;
          end
          default: begin
            next_state_s = IDLE;
          end
        endcase
      end
      SHIFT: begin
        case (config_state)
          config_middle: begin
            if (bit_cnt_r < CNT_LAST_MID) begin
              shift_nxt_s = shifted_s;
              cnt_nxt_s   = cnt_inc_s;
            end else begin
              // One more middle bit than the frame can hold.
              error_nxt_s  = 1'b1;
              next_state_s = IDLE;
            end
          end
          config_last: begin
            shift_nxt_s = shifted_s;
            cnt_nxt_s   = cnt_inc_s;
            if (cnt_inc_s == CNT_FULL) begin
              next_state_s = WAIT_DONE;
            end else begin
              error_nxt_s  = 1'b1;
              next_state_s = IDLE;
            end
          end
          config_start: begin
            // Sender restarted: drop the partial frame, keep this bit.
            error_nxt_s  = 1'b1;
            shift_nxt_s  = shifted_s;
            cnt_nxt_s    = CNT_ONE;
            next_state_s = SHIFT;
          end
          config_done: begin
            error_nxt_s  = 1'b1;
            next_state_s = IDLE;
          end
          default: begin
            next_state_s = SHIFT;
          end
        endcase
      end
      WAIT_DONE: begin
        case (config_state)
          config_done: begin
            if (start_fld_s <= end_fld_s) begin
              valid_nxt_s = 1'b1;
              load_s      = 1'b1;
            end else begin
              error_nxt_s = 1'b1;
            end
            next_state_s = IDLE;
          end
          config_start: begin
            error_nxt_s  = 1'b1;
            shift_nxt_s  = shifted_s;
            cnt_nxt_s    = CNT_ONE;
            next_state_s = SHIFT;
          end
          config_middle, config_last: begin
            error_nxt_s  = 1'b1;
            next_state_s = IDLE;
          end
          default: begin
            next_state_s = WAIT_DONE;
          end
        endcase
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, shift register, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      slave_id_r   <= '0;
      read_write_r <= 1'b0;
      ext_write_r  <= 1'b0;
      start_addr_r <= '0;
      end_addr_r   <= '0;
      cfg_valid_r  <= 1'b0;
      cfg_error_r  <= 1'b0;
      rx_busy_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= cnt_nxt_s;
      cfg_valid_r <= valid_nxt_s;
      cfg_error_r <= error_nxt_s;
      rx_busy_r   <= (next_state_s != IDLE);
      if (load_s) begin
        slave_id_r   <= sid_fld_s;
        read_write_r <= rw_fld_s;
        ext_write_r  <= ext_fld_s;
        start_addr_r <= start_fld_s;
        end_addr_r   <= end_fld_s;
      end
    end
  end

  assign slave_id   = slave_id_r;
  assign read_write = read_write_r;
  assign ext_write  = ext_write_r;
  assign start_addr = start_addr_r;
  assign end_addr   = end_addr_r;
  assign cfg_valid  = cfg_valid_r;
  assign cfg_error  = cfg_error_r;
  assign rx_busy    = rx_busy_r;

endmodule

// File: tb/tb_master_config_rx.sv
// Bench for master_config_rx: directed frames, a frame-level reference model
// checked every cycle, and hand-computed expectations per scenario.
module tb_master_config_rx;
  import top_details::*;

  localparam int FL = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  config_state = CONFIG_IDLE;
  logic        config_bit = 1'b0;
  logic [1:0]  slave_id;
  logic        read_write, ext_write;
  logic [11:0] start_addr, end_addr;
  logic        cfg_valid, cfg_error, rx_busy;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int error_seen = 0;

  // Reference model: bits of the frame in progress and what the outputs must be.
  bit          m_bits[$];
  bit          m_active = 1'b0;
  bit          m_complete = 1'b0;
  logic [1:0]  e_slave = '0;
  logic        e_rw = 1'b0, e_ext = 1'b0;
  logic [11:0] e_start = '0, e_end = '0;
  logic        e_valid = 1'b0, e_error = 1'b0, e_busy = 1'b0;

  master_config_rx dut (
    .clk(clk), .rst(rst), .config_state(config_state), .config_bit(config_bit),
    .slave_id(slave_id), .read_write(read_write), .ext_write(ext_write),
    .start_addr(start_addr), .end_addr(end_addr),
    .cfg_valid(cfg_valid), .cfg_error(cfg_error), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply the rules of the protocol to one sampled (rst, code, bit) triple.
  task automatic model_step(input logic r, input logic [2:0] code, input logic b);
    longint fr;
    e_valid = 1'b0;
    e_error = 1'b0;
    if (r) begin
      m_bits.delete();
      m_active = 1'b0; m_complete = 1'b0;
      e_slave = '0; e_rw = 1'b0; e_ext = 1'b0; e_start = '0; e_end = '0;
    end else if (code == config_start) begin
      if (m_active) e_error = 1'b1;
      m_bits.delete();
      m_bits.push_back(b);
      m_active = 1'b1; m_complete = 1'b0;
    end else if (code == config_middle || code == config_last) begin
      if (!m_active || m_complete) begin
        e_error = 1'b1;
        m_active = 1'b0;
      end else if (code == config_middle) begin
        if (m_bits.size() < FL - 1) m_bits.push_back(b);
        else begin e_error = 1'b1; m_active = 1'b0; end
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == FL) m_complete = 1'b1;
        else begin e_error = 1'b1; m_active = 1'b0; end
      end
    end else if (code == config_done) begin
      if (m_active && !m_complete) e_error = 1'b1;
      else if (m_active) begin
        fr = 0;
        foreach (m_bits[i]) fr = (fr << 1) | longint'(m_bits[i]);
        if (((fr >> 12) & 'hFFF) <= (fr & 'hFFF)) begin
          e_valid = 1'b1;
          e_slave = 2'(fr >> 26);
          e_rw    = 1'(fr >> 25);
          e_ext   = 1'(fr >> 24);
          e_start = 12'(fr >> 12);
          e_end   = 12'(fr);
        end else e_error = 1'b1;
      end
      m_active = 1'b0; m_complete = 1'b0;
    end
    e_busy = m_active;
  endtask

  // Compare every output with the model after each edge.
  task automatic compare();
    check("slave_id", 32'(slave_id), 32'(e_slave));
    check("read_write", 32'(read_write), 32'(e_rw));
    check("ext_write", 32'(ext_write), 32'(e_ext));
    check("start_addr", 32'(start_addr), 32'(e_start));
    check("end_addr", 32'(end_addr), 32'(e_end));
    check("cfg_valid", 32'(cfg_valid), 32'(e_valid));
    check("cfg_error", 32'(cfg_error), 32'(e_error));
    check("rx_busy", 32'(rx_busy), 32'(e_busy));
    if (cfg_valid === 1'b1) valid_seen++;
    if (cfg_error === 1'b1) error_seen++;
  endtask

  task automatic cycle(input logic r, input logic [2:0] code, input logic b);
    rst = r; config_state = code; config_bit = b;
    model_step(r, code, b);
    @(posedge clk);
    #1;
    compare();
  endtask

  function automatic logic [27:0] mkf(input logic [1:0] sid, input logic rw, input logic ext,
                                      input logic [11:0] sa, input logic [11:0] ea);
    return {sid, rw, ext, sa, ea};
  endfunction

  // Send nbits of fr MSB-first; last bit as config_last when end_last, else middle.
  task automatic send_frame(input logic [27:0] fr, input int nbits, input bit end_last,
                            input int stall1, input int stall2, input int rst_at, input bit with_done);
    logic [2:0] code;
    logic       b;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        cycle(1'b1, CONFIG_IDLE, 1'b0);
        return;
      end
      if (i == 0) code = config_start;
      else if (i == nbits - 1 && end_last) code = config_last;
      else code = config_middle;
      b = (i < FL) ? fr[FL-1-i] : 1'b0;
      cycle(1'b0, code, b);
      if (i == stall1 || i == stall2) repeat (3) cycle(1'b0, CONFIG_IDLE, 1'b0);
    end
    if (with_done) cycle(1'b0, config_done, 1'b0);
  endtask

  task automatic clr_counts();
    valid_seen = 0;
    error_seen = 0;
  endtask

  initial begin
    logic [27:0] f1, f2;
    f1 = mkf(2'd2, 1'b1, 1'b0, 12'h010, 12'h01F);
    f2 = mkf(2'd1, 1'b0, 1'b1, 12'h100, 12'h1FF);

    // Reset state
    cycle(1'b1, CONFIG_IDLE, 1'b0);
    cycle(1'b1, CONFIG_IDLE, 1'b0);
    check("reset_slave", 32'(slave_id), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    cycle(1'b0, CONFIG_IDLE, 1'b0);

    // Valid write frame, back-to-back bits
    clr_counts();
    send_frame(f1, 28, 1'b1, -1, -1, -1, 1'b1);
    check("t1_valid_pulses", 32'(valid_seen), 32'd1);
    check("t1_error_pulses", 32'(error_seen), 32'd0);
    check("t1_slave", 32'(slave_id), 32'd2);
    check("t1_rw", 32'(read_write), 32'd1);
    check("t1_ext", 32'(ext_write), 32'd0);
    check("t1_start", 32'(start_addr), 32'h010);
    check("t1_end", 32'(end_addr), 32'h01F);

    // Same frame with stalls after bits 5 and 20
    clr_counts();
    send_frame(f1, 28, 1'b1, 4, 19, -1, 1'b1);
    check("t2_valid_pulses", 32'(valid_seen), 32'd1);
    check("t2_start", 32'(start_addr), 32'h010);

    // Short frame: config_last on bit 27
    clr_counts();
    send_frame(f2, 27, 1'b1, -1, -1, -1, 1'b0);
    cycle(1'b0, config_done, 1'b0);
    check("t3_error_pulses", 32'(error_seen), 32'd1);
    check("t3_valid_pulses", 32'(valid_seen), 32'd0);
    check("t3_slave_kept", 32'(slave_id), 32'd2);
    check("t3_end_kept", 32'(end_addr), 32'h01F);

    // Overlength: 28th bit as middle, then a valid frame
    clr_counts();
    send_frame(f2, 28, 1'b0, -1, -1, -1, 1'b0);
    check("t4_busy_after_over", 32'(rx_busy), 32'd0);
    send_frame(f2, 28, 1'b1, -1, -1, -1, 1'b1);
    check("t4_error_pulses", 32'(error_seen), 32'd1);
    check("t4_valid_pulses", 32'(valid_seen), 32'd1);
    check("t4_slave", 32'(slave_id), 32'd1);
    check("t4_ext", 32'(ext_write), 32'd1);
    check("t4_start", 32'(start_addr), 32'h100);
    check("t4_end", 32'(end_addr), 32'h1FF);

    // Address order: start > end rejected, start == end accepted
    clr_counts();
    send_frame(mkf(2'd3, 1'b1, 1'b1, 12'h020, 12'h01F), 28, 1'b1, -1, -1, -1, 1'b1);
    check("t5_error_pulses", 32'(error_seen), 32'd1);
    check("t5_start_kept", 32'(start_addr), 32'h100);
    send_frame(mkf(2'd0, 1'b0, 1'b0, 12'h7FF, 12'h7FF), 28, 1'b1, -1, -1, -1, 1'b1);
    check("t5_valid_pulses", 32'(valid_seen), 32'd1);
    check("t5_start_eq", 32'(start_addr), 32'h7FF);
    check("t5_end_eq", 32'(end_addr), 32'h7FF);

    // Reset at bit 14: no pulse, outputs cleared
    clr_counts();
    send_frame(f1, 28, 1'b1, -1, -1, 14, 1'b1);
    cycle(1'b0, CONFIG_IDLE, 1'b0);
    check("t6_no_pulses", 32'(valid_seen + error_seen), 32'd0);
    check("t6_start_zero", 32'(start_addr), 32'd0);
    check("t6_busy", 32'(rx_busy), 32'd0);

    // Restart mid-SHIFT, then valid frame from that bit
    clr_counts();
    send_frame(f2, 10, 1'b0, -1, -1, -1, 1'b0);
    send_frame(f1, 28, 1'b1, -1, -1, -1, 1'b1);
    check("t7_error_pulses", 32'(error_seen), 32'd1);
    check("t7_valid_pulses", 32'(valid_seen), 32'd1);
    check("t7_slave", 32'(slave_id), 32'd2);

    // Restart from WAIT_DONE, then back-to-back frames with no gap
    clr_counts();
    send_frame(f1, 28, 1'b1, -1, -1, -1, 1'b0);
    send_frame(f2, 28, 1'b1, -1, -1, -1, 1'b1);
    send_frame(f1, 28, 1'b1, -1, -1, -1, 1'b1);
    check("t8_error_pulses", 32'(error_seen), 32'd1);
    check("t8_valid_pulses", 32'(valid_seen), 32'd2);
    check("t8_end", 32'(end_addr), 32'h01F);

    // Stray codes in IDLE: middle errors, done ignored
    clr_counts();
    cycle(1'b0, config_middle, 1'b1);
    cycle(1'b0, config_done, 1'b0);
    cycle(1'b0, config_last, 1'b0);
    cycle(1'b0, CONFIG_IDLE, 1'b0);
    check("t9_error_pulses", 32'(error_seen), 32'd2);
    check("t9_slave_kept", 32'(slave_id), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
